forward_unit: RTL and testbench

- Pipeline data-forwarding (bypass) control unit for the datapath's EX stage.
- Compares the ID/EX source register addresses RS and RT with the destination addresses held in the EX/MEM and MEM/WB pipeline registers.
- Produces two 2-bit mux selects:
  - HM steers operand A (RS path).
  - LM steers operand B (RT path).
- Selects are registered on the single clock and feed the EX-stage operand muxes.

---
 rtl/forward_pkg.sv | 11 +
 rtl/forward_unit_if.sv | 27 ++
 rtl/forward_sel.sv | 33 +++
 rtl/forward_unit.sv | 50 +++++
 tb/tb_forward_unit.sv | 133 +++++++++++++
 5 files changed

// File: rtl/forward_pkg.sv
// Shared select encoding for the EX-stage operand bypass muxes.
// Both the RS and RT paths use this encoding.
package forward_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE  = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

endpackage : forward_pkg

// File: rtl/forward_unit_if.sv
// Bundle of ID/EX source addresses, later-stage destinations and the registered selects.
// The datapath side drives the addresses; the forward unit drives HM/LM.
interface forward_unit_if #(
  parameter int unsigned ADDR_W = 4
);
  import forward_pkg::*;

  logic [ADDR_W-1:0] RT;
  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] EMRD;
  logic [ADDR_W-1:0] MWRD;
  logic              em_reg_write;
  logic              mw_reg_write;
  fwd_sel_t          HM;
  fwd_sel_t          LM;

  modport master (
    output RT, RS, EMRD, MWRD, em_reg_write, mw_reg_write,
    input  HM, LM
  );

  modport slave (
    input  RT, RS, EMRD, MWRD, em_reg_write, mw_reg_write,
    output HM, LM
  );

endinterface : forward_unit_if

// File: rtl/forward_sel.sv
// Combinational forward select for one source operand.
// The EX/MEM result is newer than MEM/WB, so it takes priority when both match.
module forward_sel
  import forward_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter bit          EXCLUDE_ZERO = 1'b0
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] EMRD,
  input  logic [ADDR_W-1:0] MWRD,
  input  logic              em_reg_write,
  input  logic              mw_reg_write,
  output fwd_sel_t          sel
);

  logic em_hit;
  logic mw_hit;

  // A zero destination is ignored only when register 0 is hard-wired.
  assign em_hit = em_reg_write && (EMRD == src) && !(EXCLUDE_ZERO && (EMRD == '0));
  assign mw_hit = mw_reg_write && (MWRD == src) && !(EXCLUDE_ZERO && (MWRD == '0));

  always_comb begin
    sel = FWD_NONE;
    if (em_hit) begin
      sel = FWD_EXMEM;
    end else if (mw_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule : forward_sel

// File: rtl/forward_unit.sv
// EX-stage bypass control: per-operand select logic followed by one register stage.
// Index 0 is the RS path (HM), index 1 is the RT path (LM).
module forward_unit
  import forward_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter bit          EXCLUDE_ZERO = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  forward_unit_if.slave  bus
);

  localparam int unsigned NUM_SRC = 2;

  logic [ADDR_W-1:0] src      [NUM_SRC];
  fwd_sel_t          sel_next [NUM_SRC];
  fwd_sel_t          sel_reg  [NUM_SRC];

  assign src[0] = bus.RS;
  assign src[1] = bus.RT;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_path
      forward_sel #(
        .ADDR_W       (ADDR_W),
        .EXCLUDE_ZERO (EXCLUDE_ZERO)
      ) u_sel (
        .src          (src[gi]),
        .EMRD         (bus.EMRD),
        .MWRD         (bus.MWRD),
        .em_reg_write (bus.em_reg_write),
        .mw_reg_write (bus.mw_reg_write),
        .sel          (sel_next[gi])
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sel_reg[gi] <= FWD_NONE;
        end else begin
          sel_reg[gi] <= sel_next[gi];
        end
      end
    end
  endgenerate

  assign bus.HM = sel_reg[0];
  assign bus.LM = sel_reg[1];

endmodule : forward_unit

// File: tb/tb_forward_unit.sv
// Self-checking bench for forward_unit: directed plan vectors, reset behaviour and random stimulus
// against a rule-level model; a second instance covers the hard-wired zero register.
module tb_forward_unit;
  import forward_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  forward_unit_if #(.ADDR_W(4)) bus0 ();
  forward_unit_if #(.ADDR_W(4)) bus1 ();

  forward_unit #(.ADDR_W(4), .EXCLUDE_ZERO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  forward_unit #(.ADDR_W(4), .EXCLUDE_ZERO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference: newest writer wins; a disabled or zero (when excluded) destination never matches.
  function automatic logic [1:0] model_sel(input int s, input int emrd, input int mwrd,
                                           input bit emw, input bit mww, input bit excl);
    bit em_ok = emw && (emrd == s) && !(excl && emrd == 0);
    bit mw_ok = mww && (mwrd == s) && !(excl && mwrd == 0);
    if (em_ok) return 2'b10;
    if (mw_ok) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input int rs, input int rt, input int emrd, input int mwrd,
                       input bit emw, input bit mww);
    bus0.RS = 4'(rs);   bus1.RS = 4'(rs);
    bus0.RT = 4'(rt);   bus1.RT = 4'(rt);
    bus0.EMRD = 4'(emrd); bus1.EMRD = 4'(emrd);
    bus0.MWRD = 4'(mwrd); bus1.MWRD = 4'(mwrd);
    bus0.em_reg_write = emw; bus1.em_reg_write = emw;
    bus0.mw_reg_write = mww; bus1.mw_reg_write = mww;
  endtask

  task automatic vec(input string tag, input int rs, input int rt, input int emrd, input int mwrd,
                     input bit emw, input bit mww, input logic [1:0] exp_hm, input logic [1:0] exp_lm);
    @(negedge clk);
    drive(rs, rt, emrd, mwrd, emw, mww);
    @(posedge clk);
    #1;
    check_eq({tag, "_hm"}, bus0.HM, exp_hm);
    check_eq({tag, "_lm"}, bus0.LM, exp_lm);
    $display("vec %s rs=%0h rt=%0h emrd=%0h mwrd=%0h emw=%0b mww=%0b hm=%b lm=%b",
             tag, rs, rt, emrd, mwrd, emw, mww, bus0.HM, bus0.LM);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(5, 5, 5, 5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_eq("reset_hm", bus0.HM, 2'b00);
    check_eq("reset_lm", bus0.LM, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_release_hold_hm", bus0.HM, 2'b00);

    vec("no_hazard", 'hB, 'hA, 'hC, 'hD, 1'b1, 1'b1, 2'b00, 2'b00);
    vec("mw_rt",     9,   8,   3,   8,   1'b1, 1'b1, 2'b00, 2'b01);
    vec("split",     'hE, 'hF, 'hF, 'hE, 1'b1, 1'b1, 2'b01, 2'b10);
    vec("swapped",   'hE, 'hF, 'hE, 'hF, 1'b1, 1'b1, 2'b10, 2'b01);
    vec("prio",      5,   5,   5,   5,   1'b1, 1'b1, 2'b10, 2'b10);
    vec("em_off",    5,   5,   5,   5,   1'b0, 1'b1, 2'b01, 2'b01);
    vec("both_off",  5,   5,   5,   5,   1'b0, 1'b0, 2'b00, 2'b00);

    vec("zero_cmp",  0,   7,   0,   3,   1'b1, 1'b1, 2'b10, 2'b00);
    check_eq("zero_excl_hm", bus1.HM, 2'b00);
    vec("zero_mw",   0,   0,   4,   0,   1'b1, 1'b1, 2'b01, 2'b01);
    check_eq("zero_excl_mw_hm", bus1.HM, 2'b00);
    check_eq("zero_excl_mw_lm", bus1.LM, 2'b00);

    // Asynchronous clear between edges, hold while asserted, resume after release.
    vec("pre_reset", 6, 2, 6, 1, 1'b1, 1'b1, 2'b10, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_hm", bus0.HM, 2'b00);
    check_eq("async_rst_lm", bus0.LM, 2'b00);
    @(posedge clk);
    #1;
    check_eq("rst_hold_hm", bus0.HM, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_release_hm", bus0.HM, 2'b00);
    @(posedge clk);
    #1;
    check_eq("resume_hm", bus0.HM, 2'b10);
    check_eq("resume_lm", bus0.LM, 2'b00);
    $display("reset sequence done hm=%b lm=%b", bus0.HM, bus0.LM);

    for (int i = 0; i < 300; i++) begin
      int rs, rt, emrd, mwrd;
      bit emw, mww;
      rs   = (i % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      rt   = int'($urandom_range(0, 3));
      emrd = int'($urandom_range(0, 3));
      mwrd = int'($urandom_range(0, 3));
      emw  = 1'($urandom_range(0, 1));
      mww  = 1'($urandom_range(0, 1));
      @(negedge clk);
      drive(rs, rt, emrd, mwrd, emw, mww);
      @(posedge clk);
      #1;
      check_eq("rnd_hm",    bus0.HM, model_sel(rs, emrd, mwrd, emw, mww, 1'b0));
      check_eq("rnd_lm",    bus0.LM, model_sel(rt, emrd, mwrd, emw, mww, 1'b0));
      check_eq("rnd_z_hm",  bus1.HM, model_sel(rs, emrd, mwrd, emw, mww, 1'b1));
      check_eq("rnd_z_lm",  bus1.LM, model_sel(rt, emrd, mwrd, emw, mww, 1'b1));
      $display("rnd %0d rs=%0h rt=%0h emrd=%0h mwrd=%0h emw=%0b mww=%0b hm=%b lm=%b zhm=%b zlm=%b",
               i, rs, rt, emrd, mwrd, emw, mww, bus0.HM, bus0.LM, bus1.HM, bus1.LM);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_forward_unit
